cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among the four execution issue units: integer, multiply, divide and memory.
- Each unit pushes its completed result (ROB tag plus data) into a small per-unit result queue.
- A round-robin arbiter selects one queued result per cycle and drives it onto a registered CDB broadcast port, which feeds the reservation stations, register status table and ROB.
- Back-pressure to each unit is a per-unit ready signal.

---
 rtl/cdb_arbiter.sv | 124 ++++++++++++
 tb/tb_cdb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four per-unit result FIFOs, round-robin selection,
// registered broadcast of one result per cycle.
module cdb_arbiter #(
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic [3:0]            i_req_valid,
    input  logic [4*TAG_W-1:0]    i_req_tag,
    input  logic [4*DATA_W-1:0]   i_req_data,
    output logic [3:0]            o_req_ready,
    output logic                  o_cdb_valid,
    output logic [TAG_W-1:0]      o_cdb_tag,
    output logic [DATA_W-1:0]     o_cdb_data,
    output logic [1:0]            o_cdb_src
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [TAG_W-1:0]  r_tag_mem  [4][QDEPTH];
    logic [DATA_W-1:0] r_data_mem [4][QDEPTH];
    logic [PW-1:0]     r_rd_ptr   [4];
    logic [PW-1:0]     r_wr_ptr   [4];
    logic [CW-1:0]     r_cnt      [4];
    logic [1:0]        r_rr_ptr;

    logic              r_cdb_valid;
    logic [TAG_W-1:0]  r_cdb_tag;
    logic [DATA_W-1:0] r_cdb_data;
    logic [1:0]        r_cdb_src;

    logic [3:0]        w_ready;
    logic [3:0]        w_nonempty;
    logic [3:0]        w_enq;
    logic [3:0]        w_deq;
    logic              w_grant_vld;
    logic [1:0]        w_grant_idx;
    logic [1:0]        w_scan_idx;

    // Ready comes from registered occupancy only, so a full queue never
    // advertises a slot that is being freed on the same edge.
    always_comb begin
        w_ready    = '0;
        w_nonempty = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_ready[i]    = (r_cnt[i] != CW'(QDEPTH));
            w_nonempty[i] = (r_cnt[i] != '0);
        end
        o_req_ready = i_rst ? '0 : w_ready;
        w_enq       = i_req_valid & w_ready;
    end

    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_rr_ptr;
        w_scan_idx  = r_rr_ptr;
        for (int unsigned k = 0; k < 4; k++) begin
            w_scan_idx = r_rr_ptr + k[1:0];
            if (!w_grant_vld && w_nonempty[w_scan_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
        w_deq = w_grant_vld ? (4'b0001 << w_grant_idx) : 4'b0000;
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (!i_rst && !i_flush && w_enq[i]) begin
                r_tag_mem[i][r_wr_ptr[i]]  <= i_req_tag[i*TAG_W +: TAG_W];
                r_data_mem[i][r_wr_ptr[i]] <= i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_enq[i])
                    r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
                if (w_deq[i])
                    r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
                case ({w_enq[i], w_deq[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (w_grant_vld) begin
                r_cdb_valid <= 1'b1;
                r_cdb_tag   <= r_tag_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
                r_cdb_data  <= r_data_mem[w_grant_idx][r_rd_ptr[w_grant_idx]];
                r_cdb_src   <= w_grant_idx;
                r_rr_ptr    <= w_grant_idx + 2'd1;
            end else begin
                r_cdb_valid <= 1'b0;
                r_cdb_tag   <= '0;
                r_cdb_data  <= '0;
                r_cdb_src   <= '0;
            end
        end
    end

    assign o_cdb_valid = r_cdb_valid;
    assign o_cdb_tag   = r_cdb_tag;
    assign o_cdb_data  = r_cdb_data;
    assign o_cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single result, simultaneous requests,
// back-pressure, saturation fairness, flush and mid-stream reset.
module tb_cdb_arbiter;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [3:0]          req_valid;
    logic [4*TAG_W-1:0]  req_tag;
    logic [4*DATA_W-1:0] req_data;
    logic [3:0]          req_ready;
    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_data;
    logic [1:0]          cdb_src;

    int n_vec = 0;
    int n_err = 0;

    cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .QDEPTH(2)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_req_valid (req_valid),
        .i_req_tag   (req_tag),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_cdb_valid (cdb_valid),
        .o_cdb_tag   (cdb_tag),
        .o_cdb_data  (cdb_data),
        .o_cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic chk_cdb(input string name, input logic v, input logic [1:0] src,
                           input logic [5:0] tag, input logic [31:0] data);
        chk({name, ".valid"}, 64'(cdb_valid), 64'(v));
        chk({name, ".src"},   64'(cdb_src),   64'(src));
        chk({name, ".tag"},   64'(cdb_tag),   64'(tag));
        chk({name, ".data"},  64'(cdb_data),  64'(data));
    endtask

    function automatic logic [31:0] dat(input logic [5:0] t);
        return 32'hC0DE_0000 | {26'd0, t};
    endfunction

    task automatic put(input int i, input logic [5:0] t);
        req_tag[i*TAG_W +: TAG_W]    = t;
        req_data[i*DATA_W +: DATA_W] = dat(t);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 4'b0000;
        req_tag = '0; req_data = '0;
        #1;
        chk("rst_ready_pre", 64'(req_ready), 64'h0);
        step();
        chk_cdb("rst_out", 1'b0, 2'd0, 6'h00, 32'h0);
        chk("rst_ready", 64'(req_ready), 64'h0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 64'(req_ready), 64'hF);

        // Test 1: single result with one-cycle latency
        put(0, 6'h05);
        req_data[31:0] = 32'hDEAD_BEEF;
        req_valid = 4'b0001;
        step();
        chk("t1_nobypass", 64'(cdb_valid), 64'h0);
        chk("t1_ready", 64'(req_ready), 64'hF);
        req_valid = 4'b0000;
        step();
        chk_cdb("t1_bcast", 1'b1, 2'd0, 6'h05, 32'hDEAD_BEEF);
        step();
        chk_cdb("t1_idle", 1'b0, 2'd0, 6'h00, 32'h0);

        // Test 2: four simultaneous results from rr_ptr = 0
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t2_ready", 64'(req_ready), 64'hF);
        for (int i = 0; i < 4; i++) put(i, 6'(i + 1));
        req_valid = 4'b1111;
        step();
        chk("t2_nobypass", 64'(cdb_valid), 64'h0);
        req_valid = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            step();
            chk_cdb("t2_bcast", 1'b1, 2'(s), 6'(s + 1), dat(6'(s + 1)));
        end
        step();
        chk("t2_idle", 64'(cdb_valid), 64'h0);

        // Test 3: div back-pressure while mult stays busy
        put(1, 6'h10); put(2, 6'h20); req_valid = 4'b0110;
        step();
        chk("t3_a1_valid", 64'(cdb_valid), 64'h0);
        chk("t3_a1_ready", 64'(req_ready), 64'hF);
        put(1, 6'h11); put(2, 6'h21);
        step();
        chk_cdb("t3_a2", 1'b1, 2'd1, 6'h10, dat(6'h10));
        chk("t3_a2_ready", 64'(req_ready), 64'b1011);
        put(1, 6'h12); put(2, 6'h22);
        step();
        chk_cdb("t3_a3", 1'b1, 2'd2, 6'h20, dat(6'h20));
        chk("t3_a3_ready", 64'(req_ready), 64'b1101);
        req_valid = 4'b0100;
        step();
        chk_cdb("t3_a4", 1'b1, 2'd1, 6'h11, dat(6'h11));
        chk("t3_a4_ready", 64'(req_ready), 64'b1011);
        req_valid = 4'b0000;
        step();
        chk_cdb("t3_a5", 1'b1, 2'd2, 6'h21, dat(6'h21));
        step();
        chk_cdb("t3_a6", 1'b1, 2'd1, 6'h12, dat(6'h12));
        step();
        chk_cdb("t3_a7", 1'b1, 2'd2, 6'h22, dat(6'h22));
        step();
        chk("t3_idle", 64'(cdb_valid), 64'h0);

        // Test 4: saturation, grants rotate 0,1,2,3
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) put(i, 6'(8'h30 + i));
        req_valid = 4'b1111;
        step();
        chk("t4_first", 64'(cdb_valid), 64'h0);
        for (int n = 0; n < 11; n++) begin
            step();
            chk_cdb("t4_rot", 1'b1, 2'(n % 4), 6'(8'h30 + (n % 4)), dat(6'(8'h30 + (n % 4))));
        end
        req_valid = 4'b0000;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_valid", 64'(cdb_valid), 64'h0);
        chk("t4_flush_ready", 64'(req_ready), 64'hF);

        // Test 5: flush with queued results and a simultaneous enqueue
        put(0, 6'h3A); put(1, 6'h3B); put(2, 6'h3C); req_valid = 4'b0111;
        step();
        chk("t5_fill", 64'(cdb_valid), 64'h0);
        flush = 1'b1;
        put(0, 6'h3F); req_valid = 4'b0001;
        step();
        flush = 1'b0; req_valid = 4'b0000;
        chk_cdb("t5_flush", 1'b0, 2'd0, 6'h00, 32'h0);
        chk("t5_ready", 64'(req_ready), 64'hF);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t5_quiet", 64'(cdb_valid), 64'h0);
        end

        // Test 6: reset with two results queued
        put(0, 6'h11); put(3, 6'h14); req_valid = 4'b1001;
        step();
        chk("t6_fill", 64'(cdb_valid), 64'h0);
        req_valid = 4'b0000;
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", 64'(req_ready), 64'h0);
        step();
        chk_cdb("t6_rst_out", 1'b0, 2'd0, 6'h00, 32'h0);
        chk("t6_rst_ready2", 64'(req_ready), 64'h0);
        rst = 1'b0;
        put(2, 6'h25); req_valid = 4'b0100;
        #1;
        chk("t6_rel_ready", 64'(req_ready), 64'hF);
        step();
        chk("t6_no_stale", 64'(cdb_valid), 64'h0);
        req_valid = 4'b0000;
        step();
        chk_cdb("t6_new", 1'b1, 2'd2, 6'h25, dat(6'h25));
        step();
        chk("t6_idle1", 64'(cdb_valid), 64'h0);
        step();
        chk("t6_idle2", 64'(cdb_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
